// File: rtl/uart_mmio_fifo.sv
// Byte FIFO with an extra pointer MSB that separates full from empty.
// Latency: a pushed byte is visible at head_dat the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module uart_mmio_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld,
  input  logic [7:0] push_dat,
  input  logic       pop_vld,
  output logic [7:0] head_dat,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // A same-cycle pop frees the slot a push into a full FIFO needs.
  always_comb begin
    do_pop   = pop_vld & ~empty;
    do_push  = push_vld & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end
endmodule

// Memory-mapped UART: TX/RX byte FIFOs, serializer/deserializer, sticky errors, loopback, level IRQ.
// Latency: register reads combinational; tx starts one cycle after a DATA store into an idle TX; irq lags status by one cycle.
// Backpressure: none on the bus; bytes to a full TX FIFO are dropped (tx_drop), bytes received into a full RX FIFO are dropped (rx_overrun).
module uart_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'h10010000,
  parameter int          TX_DEPTH   = 8,
  parameter int          RX_DEPTH   = 8,
  parameter logic [15:0] BAUD_RESET = 16'h0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        sel,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  localparam logic [3:0] OFF_DATA = 4'h0, OFF_STATUS = 4'h4, OFF_CTRL = 4'h8, OFF_BAUD = 4'hC;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d, baud_wr;
  logic        rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d, tx_drop_q, tx_drop_d;
  logic        irq_q, irq_d;
  state_e      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_per_q, tx_per_d, rx_cnt_q, rx_cnt_d, rx_per_q, rx_per_d, rx_half;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic        tx_q, tx_d, tx_load;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_line, rx_frame_bad;
  logic        tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head, status;
  logic [3:0]  off;
  logic        bus_wr, tx_busy, unused_bits;

  assign sel         = (address[31:4] == BASE_ADDR[31:4]);
  assign off         = address[3:0];
  assign bus_wr      = sel & write_enable;
  assign tx_push     = bus_wr & write_mask[0] & (off == OFF_DATA);
  assign rx_pop      = sel & read_enable & (off == OFF_DATA);
  assign tx_busy     = (tx_state_q != S_IDLE);
  assign status      = {tx_drop_q, frame_err_q, rx_overrun_q, tx_busy, tx_full, tx_empty, rx_full, ~rx_empty};
  assign rx_line     = ctrl_q[0] ? tx_q : rx_sync_q;
  assign tx          = tx_q;
  assign irq         = irq_q;
  assign unused_bits = ^{write_data[31:16], write_mask[3:2]};

  uart_mmio_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_vld(tx_push), .push_dat(write_data[7:0]), .pop_vld(tx_pop),
    .head_dat(tx_head), .full(tx_full), .empty(tx_empty));

  uart_mmio_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_vld(rx_push), .push_dat(rx_shift_q), .pop_vld(rx_pop),
    .head_dat(rx_head), .full(rx_full), .empty(rx_empty));

  // Register read mux; unmapped offsets and an empty RX FIFO read as zero.
  always_comb begin
    read_data = '0;
    if (sel) begin
      case (off)
        OFF_DATA:   read_data = {24'h0, rx_empty ? 8'h00 : rx_head};
        OFF_STATUS: read_data = {24'h0, status};
        OFF_CTRL:   read_data = {29'h0, ctrl_q};
        OFF_BAUD:   read_data = {16'h0, baud_q};
        default:    read_data = '0;
      endcase
    end
  end

  // Control registers and sticky flags; a new error event wins over a same-cycle clear.
  always_comb begin
    ctrl_d       = ctrl_q;
    baud_d       = baud_q;
    baud_wr      = {write_mask[1] ? write_data[15:8] : baud_q[15:8],
                    write_mask[0] ? write_data[7:0]  : baud_q[7:0]};
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = frame_err_q;
    tx_drop_d    = tx_drop_q;
    if (bus_wr && off == OFF_STATUS && write_mask[0]) begin
      rx_overrun_d = rx_overrun_q & ~write_data[5];
      frame_err_d  = frame_err_q & ~write_data[6];
      tx_drop_d    = tx_drop_q & ~write_data[7];
    end
    if (bus_wr && off == OFF_CTRL && write_mask[0]) ctrl_d = write_data[2:0];
    if (bus_wr && off == OFF_BAUD && write_mask[1:0] != 2'b00)
      baud_d = (baud_wr == 16'h0) ? 16'h1 : baud_wr;
    if (tx_push && tx_full && !tx_pop) tx_drop_d = 1'b1;
    if (rx_push && rx_full && !rx_pop) rx_overrun_d = 1'b1;
    if (rx_frame_bad) frame_err_d = 1'b1;
    irq_d = (ctrl_q[1] & ~rx_empty) | (ctrl_q[2] & tx_empty & ~tx_busy);
  end

  // TX serializer: each state lasts baud+1 clocks; a queued byte follows the stop bit without a gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_per_d   = tx_per_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      S_IDLE:  tx_load = ~tx_empty;
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = tx_per_q;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = tx_per_q;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_IDLE;
          tx_load    = ~tx_empty;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
    endcase
    tx_pop = tx_load;
    if (tx_load) begin
      tx_state_d = S_START;
      tx_shift_d = tx_head;
      tx_cnt_d   = baud_q;
      tx_per_d   = baud_q;
      tx_d       = 1'b0;
    end
  end

  // RX deserializer: half-period wait to mid start bit, then one sample per bit period.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_per_d     = rx_per_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_frame_bad = 1'b0;
    rx_half      = {1'b0, baud_q[15:1]} + {15'h0, baud_q[0]} - 16'd1;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_line) begin
          rx_state_d = S_START;
          rx_cnt_d   = rx_half;
          rx_per_d   = baud_q;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = rx_line ? S_IDLE : S_DATA;
          rx_cnt_d   = rx_per_q;
          rx_bit_d   = 3'd0;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          rx_cnt_d   = rx_per_q;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d   = S_IDLE;
          rx_push      = rx_line;
          rx_frame_bad = ~rx_line;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
    endcase
  end

  // Two-flop synchronizer on the rx pin, plus one-cycle history of the selected line for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_line;
    end
  end

  // State registers; reset aborts any frame in flight and forces the line idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0; baud_q <= BAUD_RESET; irq_q <= 1'b0;
      rx_overrun_q <= 1'b0; frame_err_q <= 1'b0; tx_drop_q <= 1'b0;
      tx_state_q <= S_IDLE; tx_cnt_q <= '0; tx_per_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0; tx_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0; rx_per_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
    end else begin
      ctrl_q <= ctrl_d; baud_q <= baud_d; irq_q <= irq_d;
      rx_overrun_q <= rx_overrun_d; frame_err_q <= frame_err_d; tx_drop_q <= tx_drop_d;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_per_q <= tx_per_d; tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d; tx_q <= tx_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_per_q <= rx_per_d; rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: register table, serial waveform, loopback, FIFO limits, errors, irq, reset.
// Latency: bus accesses take one clock; reads sampled mid-cycle.
// Backpressure: none; the scoreboard holds bytes expected back from DATA reads.
module tb_uart_mmio_fifo;
  localparam logic [31:0] BASE = 32'h10010000;
  localparam logic [3:0]  O_DATA = 4'h0, O_STATUS = 4'h4, O_CTRL = 4'h8, O_BAUD = 4'hC;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] address = '0, write_data = '0, read_data;
  logic [3:0]  write_mask = '0;
  logic        write_enable = 1'b0, read_enable = 1'b0, sel, rx = 1'b1, tx, irq;

  int n_checks = 0, n_fail = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic        wr;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[17];

  uart_mmio_fifo dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data), .write_mask(write_mask),
    .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data), .sel(sel),
    .rx(rx), .tx(tx), .irq(irq));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
    address = BASE | {28'h0, off}; write_data = d; write_mask = m; write_enable = 1'b1;
    tick();
    write_enable = 1'b0; write_mask = '0; address = '0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
    address = BASE | {28'h0, off}; read_enable = 1'b1;
    #1 d = read_data;
    tick();
    read_enable = 1'b0; address = '0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(off, d);
    check(name, d, exp);
  endtask

  task automatic check_pop(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    bus_read(O_DATA, d);
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got %h, expected no data (scoreboard empty)", name, d);
    end else begin
      e = sb.pop_front();
      check(name, d, {24'h0, e});
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0; repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; repeat (4) tick();
    end
    rx = stop_bit; repeat (4) tick();
    rx = 1'b1; repeat (8) tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  fr;
    logic        samp[100];

    vecs[0]  = '{1'b0, O_STATUS, 32'h0,         4'h0, 32'h04};
    vecs[1]  = '{1'b0, O_CTRL,   32'h0,         4'h0, 32'h0};
    vecs[2]  = '{1'b0, O_BAUD,   32'h0,         4'h0, 32'h3};
    vecs[3]  = '{1'b0, O_DATA,   32'h0,         4'h0, 32'h0};
    vecs[4]  = '{1'b1, O_BAUD,   32'h0000_1234, 4'h3, 32'h0};
    vecs[5]  = '{1'b0, O_BAUD,   32'h0,         4'h0, 32'h1234};
    vecs[6]  = '{1'b1, O_BAUD,   32'hFFFF_0000, 4'h3, 32'h0};
    vecs[7]  = '{1'b0, O_BAUD,   32'h0,         4'h0, 32'h1};
    vecs[8]  = '{1'b1, O_BAUD,   32'h0000_55AB, 4'h1, 32'h0};
    vecs[9]  = '{1'b0, O_BAUD,   32'h0,         4'h0, 32'h00AB};
    vecs[10] = '{1'b1, O_BAUD,   32'h0000_0003, 4'h3, 32'h0};
    vecs[11] = '{1'b1, O_CTRL,   32'h0000_0007, 4'h2, 32'h0};
    vecs[12] = '{1'b0, O_CTRL,   32'h0,         4'h0, 32'h0};
    vecs[13] = '{1'b1, O_CTRL,   32'h0000_00FF, 4'h1, 32'h0};
    vecs[14] = '{1'b0, O_CTRL,   32'h0,         4'h0, 32'h7};
    vecs[15] = '{1'b0, 4'h9,     32'h0,         4'h0, 32'h0};
    vecs[16] = '{1'b1, O_CTRL,   32'h0,         4'h1, 32'h0};

    repeat (3) tick();
    rst = 1'b0;
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].off, vecs[i].wd, vecs[i].mask);
      else begin
        bus_read(vecs[i].off, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end

    // Window decode.
    address = BASE + 32'h10; read_enable = 1'b1; #1;
    check("sel_outside", {31'h0, sel}, 32'h0);
    check("rdata_outside", read_data, 32'h0);
    address = BASE + 32'hC; #1;
    check("sel_inside", {31'h0, sel}, 32'h1);
    read_enable = 1'b0; address = '0;
    tick();

    // Serial waveform of 0x55 at BAUD=3: 4 clocks per bit.
    bus_write(O_DATA, 32'h55, 4'h1);
    check("tx_idle_before_start", {31'h0, tx}, 32'h1);
    tick();
    fr = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 40; c++) begin
      check($sformatf("tx_wave_c%0d", c), {31'h0, tx}, {31'h0, fr[c / 4]});
      tick();
    end
    check_reg("status_after_tx", O_STATUS, 32'h04);

    // Loopback, two frames back to back.
    bus_write(O_CTRL, 32'h1, 4'h1);
    bus_write(O_DATA, 32'hA5, 4'h1); sb.push_back(8'hA5);
    bus_write(O_DATA, 32'h3C, 4'h1); sb.push_back(8'h3C);
    for (int k = 0; k < 100; k++) begin
      samp[k] = tx;
      tick();
    end
    check("b2b_start1", {31'h0, samp[0]}, 32'h0);
    check("b2b_stop1", {31'h0, samp[39]}, 32'h1);
    check("b2b_start2", {31'h0, samp[40]}, 32'h0);
    check_pop("lb_byte0");
    check_pop("lb_byte1");
    check_reg("lb_status_empty", O_STATUS, 32'h04);

    // Nine bytes looped into an eight-entry RX FIFO.
    for (int i = 0; i < 9; i++) begin
      bus_write(O_DATA, 32'h10 + i, 4'h1);
      if (i < 8) sb.push_back(8'(8'h10 + i));
    end
    repeat (400) tick();
    check_reg("ovr_status", O_STATUS, 32'h27);
    for (int i = 0; i < 8; i++) check_pop($sformatf("ovr_byte%0d", i));
    check_reg("ovr_status_drained", O_STATUS, 32'h24);
    bus_write(O_STATUS, 32'h20, 4'h1);
    check_reg("ovr_cleared", O_STATUS, 32'h04);

    // TX FIFO overflow while busy.
    bus_write(O_CTRL, 32'h0, 4'h1);
    for (int i = 0; i < 10; i++) bus_write(O_DATA, 32'h40 + i, 4'h1);
    check_reg("drop_status", O_STATUS, 32'h98);
    bus_write(O_STATUS, 32'h80, 4'h1);
    check_reg("drop_cleared", O_STATUS, 32'h18);
    repeat (420) tick();
    check_reg("drop_drained", O_STATUS, 32'h04);

    // Framing error, then a one-clock glitch.
    send_rx(8'h5A, 1'b0);
    check_reg("frame_err_status", O_STATUS, 32'h44);
    bus_write(O_STATUS, 32'h40, 4'h1);
    rx = 1'b0; tick(); rx = 1'b1;
    repeat (60) tick();
    check_reg("glitch_no_frame", O_STATUS, 32'h04);

    // RX interrupt.
    bus_write(O_CTRL, 32'h2, 4'h1);
    send_rx(8'hC3, 1'b1); sb.push_back(8'hC3);
    check("rx_irq_set", {31'h0, irq}, 32'h1);
    check_reg("rx_status", O_STATUS, 32'h05);
    check_pop("rx_byte");
    tick();
    check("rx_irq_clear", {31'h0, irq}, 32'h0);

    // TX-idle interrupt with one-cycle lag.
    bus_write(O_CTRL, 32'h4, 4'h1);
    check("tx_irq_lag", {31'h0, irq}, 32'h0);
    tick();
    check("tx_irq_set", {31'h0, irq}, 32'h1);
    bus_write(O_CTRL, 32'h0, 4'h1);

    // Reset in the middle of a frame.
    bus_write(O_BAUD, 32'h5, 4'h3);
    bus_write(O_DATA, 32'h00, 4'h1);
    repeat (12) tick();
    check("midframe_tx_low", {31'h0, tx}, 32'h0);
    rst = 1'b1;
    tick();
    check("rst_tx_high", {31'h0, tx}, 32'h1);
    rst = 1'b0;
    check_reg("rst_baud", O_BAUD, 32'h3);
    check_reg("rst_status", O_STATUS, 32'h04);
    repeat (20) tick();
    check("rst_tx_stays_idle", {31'h0, tx}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
